aibio_pi_slew_decode_sync: RTL and testbench

AIBIO_PI_SLEW_DECODE_SYNC -- requirements
Module: aibio_pi_slew_decode_sync

---
 rtl/aibio_pi_pkg.sv | 23 ++
 rtl/aibio_pi_slew_chan.sv | 94 +++++++++
 rtl/aibio_pi_slew_decode_sync.sv | 51 +++++
 tb/tb_aibio_pi_slew_decode_sync.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aibio_pi_pkg.sv
// aibio_pi_pkg: shared widths, slew FSM states and code decode for the PI slew/decode block.
package aibio_pi_pkg;
  localparam int PI_STG2_W = 2;
  localparam int PI_STG1_W = 3;
  localparam int PI_MIX_W = 3;
  localparam int PI_CODE_W = PI_STG2_W + PI_STG1_W + PI_MIX_W;
  localparam int PI_STG1_N = 2**PI_STG1_W;
  localparam int PI_MIX_N = 2**PI_MIX_W;
  typedef enum logic {IDLE, SLEW} pi_state_e;
  typedef struct packed {
    logic [PI_STG2_W-1:0] stg2;
    logic [PI_STG1_N-1:0] stg1;
    logic [PI_MIX_N-1:0]  mix;
  } pi_dec_t;
  // stage-2 binary, stage-1 one-hot, mixer thermometer (bit i set when i < m)
  function automatic pi_dec_t pi_decode(input logic [PI_CODE_W-1:0] k);
    pi_dec_t d;
    d.stg2 = k[PI_CODE_W-1 -: PI_STG2_W];
    d.stg1 = PI_STG1_N'(1) << k[PI_MIX_W +: PI_STG1_W];
    d.mix = ~(PI_MIX_N'({PI_MIX_N{1'b1}}) << k[PI_MIX_W-1:0]);
    return d;
  endfunction
endpackage

// File: rtl/aibio_pi_slew_chan.sv
// aibio_pi_slew_chan: one PI channel -- slew FSM, step divider, code register and registered decode.
// Slewing is enabled by AIBIO_PI_SLEW_EN; without it an accepted update loads the code directly.
module aibio_pi_slew_chan
  import aibio_pi_pkg::*;
#(
  parameter int STEP_DIV = 4,
  parameter int STG2_W = PI_STG2_W,
  parameter int STG1_W = PI_STG1_W,
  parameter int MIX_W = PI_MIX_W,
  localparam int CODE_W = STG2_W + STG1_W + MIX_W,
  localparam int STG1_N = 2**STG1_W,
  localparam int MIX_N = 2**MIX_W
) (
  input  logic              i_clk_sync,
  input  logic              i_reset_n,
  input  logic              i_clk_en,
  input  logic [CODE_W-1:0] i_picode,
  input  logic              i_update,
  output logic [STG1_N-1:0] o_stg1,
  output logic [STG2_W-1:0] o_stg2,
  output logic [MIX_N-1:0]  o_mix,
  output logic [CODE_W-1:0] o_code_cur,
  output logic              o_busy,
  output logic              o_done
);
`ifdef AIBIO_PI_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif
  localparam int DW = $clog2(STEP_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [CODE_W-1:0] HALF = CODE_W'(1) << (CODE_W - 1);
  pi_state_e r_state, w_state_nxt;
  logic [CODE_W-1:0] r_code, r_tgt, w_tgt_nxt, w_code_nxt, w_code_step, w_dist;
  logic [DW-1:0] r_div, w_div_nxt;
  logic r_done, w_done_nxt, w_acc, w_step;
  logic [STG1_N-1:0] r_stg1, w_stg1;
  logic [STG2_W-1:0] r_stg2, w_stg2;
  logic [MIX_N-1:0] r_mix, w_mix;
  // shortest modulo path; the exact half-way distance resolves upward
  always_comb begin
    w_acc = i_clk_en & i_update;
    w_step = (r_state == SLEW) && (r_div == DIV_LAST);
    w_dist = r_tgt - r_code;
    w_code_step = w_step ? ((w_dist <= HALF) ? r_code + CODE_W'(1) : r_code - CODE_W'(1)) : r_code;
    w_tgt_nxt = w_acc ? i_picode : r_tgt;
    w_code_nxt = SLEW_ON ? w_code_step : (w_acc ? i_picode : r_code);
    w_state_nxt = (SLEW_ON && w_tgt_nxt != w_code_nxt) ? SLEW : IDLE;
    w_div_nxt = (r_state == SLEW && !w_step) ? r_div + DW'(1) : '0;
    w_done_nxt = !SLEW_ON ? w_acc :
                 (r_state == IDLE) ? (w_acc && i_picode == r_code) :
                 (!w_acc && w_step && w_code_step == r_tgt);
  end
  if (STG2_W == PI_STG2_W && STG1_W == PI_STG1_W && MIX_W == PI_MIX_W) begin : g_pkg
    pi_dec_t w_dec;
    assign w_dec = pi_decode(r_code);
    assign {w_stg2, w_stg1, w_mix} = w_dec;
  end else begin : g_gen
    assign w_stg2 = r_code[CODE_W-1 -: STG2_W];
    assign w_stg1 = STG1_N'(1) << r_code[MIX_W +: STG1_W];
    assign w_mix = ~(MIX_N'({MIX_N{1'b1}}) << r_code[MIX_W-1:0]);
  end
  // a disabled cycle freezes everything except the done pulse, which drops
  always_ff @(posedge i_clk_sync) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_code <= '0;
      r_tgt <= '0;
      r_div <= '0;
      r_done <= 1'b0;
      r_stg1 <= STG1_N'(1);
      r_stg2 <= '0;
      r_mix <= '0;
    end else if (i_clk_en) begin
      r_state <= w_state_nxt;
      r_code <= w_code_nxt;
      r_tgt <= w_tgt_nxt;
      r_div <= w_div_nxt;
      r_done <= w_done_nxt;
      r_stg1 <= w_stg1;
      r_stg2 <= w_stg2;
      r_mix <= w_mix;
    end else begin
      r_done <= 1'b0;
    end
  end
  assign o_stg1 = r_stg1;
  assign o_stg2 = r_stg2;
  assign o_mix = r_mix;
  assign o_code_cur = r_code;
  assign o_busy = (r_state == SLEW);
  assign o_done = r_done;
endmodule

// File: rtl/aibio_pi_slew_decode_sync.sv
// aibio_pi_slew_decode_sync: NCH independent phase-interpolator code slewers with registered decode.
// Define AIBIO_PI_SLEW_EN to slew one LSB per STEP_DIV cycles; otherwise updates load directly.
module aibio_pi_slew_decode_sync
  import aibio_pi_pkg::*;
#(
  parameter int NCH = 1,
  parameter int STEP_DIV = 4,
  parameter int STG2_W = PI_STG2_W,
  parameter int STG1_W = PI_STG1_W,
  parameter int MIX_W = PI_MIX_W,
  localparam int CODE_W = STG2_W + STG1_W + MIX_W,
  localparam int STG1_N = 2**STG1_W,
  localparam int MIX_N = 2**MIX_W
) (
  input  logic                  i_clk_sync,
  input  logic                  i_reset_n,
  input  logic                  vddcq,
  input  logic                  vss,
  input  logic                  i_clk_en,
  input  logic [NCH*CODE_W-1:0] i_picode,
  input  logic [NCH-1:0]        i_update,
  output logic [NCH*STG1_N-1:0] o_clkphsel_stg1_synced,
  output logic [NCH*STG2_W-1:0] o_clkphsel_stg2_synced,
  output logic [NCH*MIX_N-1:0]  o_pimixer_synced,
  output logic [NCH*CODE_W-1:0] o_code_cur,
  output logic [NCH-1:0]        o_busy,
  output logic [NCH-1:0]        o_done
);
  logic w_unused_supply;
  assign w_unused_supply = vddcq ^ vss;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    aibio_pi_slew_chan #(
      .STEP_DIV(STEP_DIV),
      .STG2_W(STG2_W),
      .STG1_W(STG1_W),
      .MIX_W(MIX_W)
    ) u_chan (
      .i_clk_sync(i_clk_sync),
      .i_reset_n(i_reset_n),
      .i_clk_en(i_clk_en),
      .i_picode(i_picode[c*CODE_W +: CODE_W]),
      .i_update(i_update[c]),
      .o_stg1(o_clkphsel_stg1_synced[c*STG1_N +: STG1_N]),
      .o_stg2(o_clkphsel_stg2_synced[c*STG2_W +: STG2_W]),
      .o_mix(o_pimixer_synced[c*MIX_N +: MIX_N]),
      .o_code_cur(o_code_cur[c*CODE_W +: CODE_W]),
      .o_busy(o_busy[c]),
      .o_done(o_done[c])
    );
  end
endmodule

// File: tb/tb_aibio_pi_slew_decode_sync.sv
// tb_aibio_pi_slew_decode_sync: directed vectors for the PI slew/decode block, two channels, STEP_DIV=4.
module tb_aibio_pi_slew_decode_sync;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, vddcq = 1'b1, vss = 1'b0;
  logic [15:0] picode = '0;
  logic [1:0] upd = '0;
  logic [15:0] stg1, mix, code;
  logic [3:0] stg2;
  logic [1:0] busy, done;
  int n_vec = 0, n_err = 0, n_done = 0, nd = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (done[0]) n_done++;
  aibio_pi_slew_decode_sync #(.NCH(2), .STEP_DIV(4)) dut (
    .i_clk_sync(clk),
    .i_reset_n(rst_n),
    .vddcq(vddcq),
    .vss(vss),
    .i_clk_en(en),
    .i_picode(picode),
    .i_update(upd),
    .o_clkphsel_stg1_synced(stg1),
    .o_clkphsel_stg2_synced(stg2),
    .o_pimixer_synced(mix),
    .o_code_cur(code),
    .o_busy(busy),
    .o_done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input int ch, input logic [7:0] v);
    picode[ch*8 +: 8] = v;
    upd[ch] = 1'b1;
    tick();
    upd[ch] = 1'b0;
  endtask
  initial begin
    tick(2);
    check("rst_stg1", stg1, 16'h0101);
    check("rst_stg2", stg2, 4'h0);
    check("rst_mix", mix, 16'h0000);
    check("rst_code", code, 16'h0000);
    check("rst_busy", busy, 2'b00);
    check("rst_done", done, 2'b00);
    rst_n = 1'b1;
    tick();
`ifdef AIBIO_PI_SLEW_EN
    load(0, 8'd3);
    check("up_busy", busy[0], 1'b1);
    tick(3);
    check("up_early", code[7:0], 8'd0);
    tick();
    check("up_c1", code[7:0], 8'd1);
    tick(4);
    check("up_c2", code[7:0], 8'd2);
    tick(4);
    check("up_c3", code[7:0], 8'd3);
    check("up_done", done[0], 1'b1);
    check("up_busy_fall", busy[0], 1'b0);
    tick();
    check("up_mix", mix[7:0], 8'h07);
    check("up_done_pulse", done[0], 1'b0);
    load(0, 8'd254);
    tick(20);
    check("down_wrap", code[7:0], 8'd254);
    check("down_idle", busy[0], 1'b0);
    tick();
    check("dec254_stg2", stg2[1:0], 2'd3);
    check("dec254_stg1", stg1[7:0], 8'h80);
    check("dec254_mix", mix[7:0], 8'h3f);
    load(0, 8'd2);
    tick(4);
    check("wrap_ff", code[7:0], 8'hff);
    tick(4);
    check("wrap_00", code[7:0], 8'h00);
    tick(4);
    check("wrap_01", code[7:0], 8'h01);
    tick(4);
    check("wrap_02", code[7:0], 8'h02);
    check("wrap_done", done[0], 1'b1);
    load(0, 8'd0);
    tick(8);
    check("back0", code[7:0], 8'd0);
    load(0, 8'd128);
    tick(4);
    check("tie_up", code[7:0], 8'd1);
    load(0, 8'd0);
    tick(2);
    check("tie_ret_hold", code[7:0], 8'd1);
    tick();
    check("tie_ret_code", code[7:0], 8'd0);
    check("tie_ret_done", done[0], 1'b1);
    load(0, 8'd10);
    tick(28);
    check("rt_at7", code[7:0], 8'd7);
    nd = n_done;
    load(0, 8'd5);
    tick(2);
    check("rt_hold", code[7:0], 8'd7);
    tick();
    check("rt_c6", code[7:0], 8'd6);
    tick(4);
    check("rt_c5", code[7:0], 8'd5);
    tick();
    check("rt_stg1", stg1[7:0], 8'h01);
    check("rt_mix", mix[7:0], 8'h1f);
    check("rt_one_done", n_done - nd, 1);
    load(0, 8'd8);
    tick(2);
    en = 1'b0;
    picode[7:0] = 8'd200;
    upd[0] = 1'b1;
    tick(6);
    upd[0] = 1'b0;
    check("frz_code", code[7:0], 8'd5);
    check("frz_busy", busy[0], 1'b1);
    en = 1'b1;
    tick();
    check("frz_div_kept0", code[7:0], 8'd5);
    tick();
    check("frz_div_kept1", code[7:0], 8'd6);
    tick(8);
    check("frz_arrive", code[7:0], 8'd8);
    check("frz_done", done[0], 1'b1);
    load(0, 8'd20);
    tick(4);
    check("mid_c9", code[7:0], 8'd9);
    nd = n_done;
    rst_n = 1'b0;
    picode[7:0] = 8'd50;
    upd[0] = 1'b1;
    tick();
    check("mid_rst_code", code[7:0], 8'd0);
    check("mid_rst_busy", busy[0], 1'b0);
    check("mid_rst_stg1", stg1[7:0], 8'h01);
    rst_n = 1'b1;
    tick();
    upd[0] = 1'b0;
    check("rel_busy", busy[0], 1'b1);
    check("rel_no_done", n_done - nd, 0);
    tick(4);
    check("rel_c1", code[7:0], 8'd1);
    load(0, 8'd0);
    tick(3);
    check("rel_back0", code[7:0], 8'd0);
    check("rel_back_done", done[0], 1'b1);
    load(0, 8'd0);
    check("eq_done", done[0], 1'b1);
    check("eq_busy", busy[0], 1'b0);
    load(1, 8'd1);
    check("ind_busy", busy, 2'b10);
    tick(4);
    check("ind_code", code, 16'h0100);
    check("ind_done", done, 2'b10);
`else
    load(0, 8'd3);
    check("dl_code", code[7:0], 8'd3);
    check("dl_done", done[0], 1'b1);
    check("dl_busy", busy[0], 1'b0);
    check("dl_latency", mix[7:0], 8'h00);
    tick();
    check("dl_mix", mix[7:0], 8'h07);
    check("dl_stg1", stg1[7:0], 8'h01);
    check("dl_done_pulse", done[0], 1'b0);
    load(0, 8'd254);
    check("dl_254", code[7:0], 8'd254);
    tick();
    check("dec254_stg2", stg2[1:0], 2'd3);
    check("dec254_stg1", stg1[7:0], 8'h80);
    check("dec254_mix", mix[7:0], 8'h3f);
    en = 1'b0;
    picode[7:0] = 8'd10;
    upd[0] = 1'b1;
    tick();
    upd[0] = 1'b0;
    check("dis_code", code[7:0], 8'd254);
    check("dis_done", done[0], 1'b0);
    en = 1'b1;
    load(0, 8'd254);
    check("eq_done", done[0], 1'b1);
    rst_n = 1'b0;
    picode[7:0] = 8'd50;
    upd[0] = 1'b1;
    tick();
    check("rst_code2", code[7:0], 8'd0);
    check("rst_done2", done[0], 1'b0);
    check("rst_stg1_2", stg1[7:0], 8'h01);
    rst_n = 1'b1;
    tick();
    upd[0] = 1'b0;
    check("rel_code", code[7:0], 8'd50);
    check("rel_done", done[0], 1'b1);
    check("rel_busy", busy[0], 1'b0);
    load(1, 8'd7);
    check("ind_code", code, 16'h0732);
    check("ind_done", done, 2'b10);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
